// File: rtl/fft_pkg.sv
// rtl/fft_pkg.sv - shared defaults, FSM state type and complex word type for the FFT output stage
package fft_pkg;

  localparam int FFT_N      = 8;
  localparam int FFT_DATA_W = 16;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_STREAM = 1'b1
  } state_t;

  typedef struct packed {
    logic [FFT_DATA_W-1:0] re;
    logic [FFT_DATA_W-1:0] im;
  } cplx_t;

endpackage

// File: rtl/fft_frame_buf.sv
// rtl/fft_frame_buf.sv - N-word complex frame register with parallel load, indexed read and ovf bit
import fft_pkg::*;

module fft_frame_buf #(
  parameter int N      = FFT_N,
  parameter int DATA_W = FFT_DATA_W,
  parameter int IDX_W  = $clog2(N)
) (
  input  logic                  clock,
  input  logic                  load,
  input  logic [N*DATA_W-1:0]   load_re,
  input  logic [N*DATA_W-1:0]   load_im,
  input  logic                  load_ovf,
  input  logic [IDX_W-1:0]      rd_idx,
  output logic [DATA_W-1:0]     rd_re,
  output logic [DATA_W-1:0]     rd_im,
  output logic [N*DATA_W-1:0]   vec_re,
  output logic [N*DATA_W-1:0]   vec_im,
  output logic                  ovf
);

  logic [N*DATA_W-1:0] re_q;
  logic [N*DATA_W-1:0] im_q;
  logic                ovf_q;

  // Contents are don't-care after reset, so the array carries no reset.
  always_ff @(posedge clock) begin
    if (load) begin
      re_q  <= load_re;
      im_q  <= load_im;
      ovf_q <= load_ovf;
    end
  end

  assign rd_re  = re_q[rd_idx*DATA_W +: DATA_W];
  assign rd_im  = im_q[rd_idx*DATA_W +: DATA_W];
  assign vec_re = re_q;
  assign vec_im = im_q;
  assign ovf    = ovf_q;

endmodule

// File: rtl/fft_result_streamer.sv
// rtl/fft_result_streamer.sv - captures FFT result frames and streams them one bin per cycle
import fft_pkg::*;

module fft_result_streamer #(
  parameter int N      = FFT_N,
  parameter int DATA_W = FFT_DATA_W,
  parameter int IDX_W  = $clog2(N)
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                Wr_En_X,
  input  logic [N*DATA_W-1:0] X_re_in,
  input  logic [N*DATA_W-1:0] X_im_in,
  input  logic                Overflow,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [DATA_W-1:0]   out_re,
  output logic [DATA_W-1:0]   out_im,
  output logic [IDX_W-1:0]    out_idx,
  output logic                out_last,
  output logic                out_ovf,
  output logic                busy,
  output logic                drop_err
);

  state_t             state, state_nxt;
  logic [IDX_W-1:0]   idx, idx_nxt;
  logic               pend_v, pend_v_nxt;
  logic               drop_nxt;
  logic               act_load, act_from_pend, pend_load;

  logic               streaming, xfer, at_last, last_beat;

  logic [DATA_W-1:0]   act_rd_re, act_rd_im;
  logic [N*DATA_W-1:0] act_vec_re_unused, act_vec_im_unused;
  logic                act_ovf;
  logic [DATA_W-1:0]   pend_rd_re_unused, pend_rd_im_unused;
  logic [N*DATA_W-1:0] pend_vec_re, pend_vec_im;
  logic                pend_ovf;

  assign streaming = (state == ST_STREAM);
  assign xfer      = streaming & out_ready;
  assign at_last   = (idx == IDX_W'(N-1));
  assign last_beat = xfer & at_last;

  always_comb begin
    state_nxt     = state;
    idx_nxt       = idx;
    pend_v_nxt    = pend_v;
    drop_nxt      = 1'b0;
    act_load      = 1'b0;
    act_from_pend = 1'b0;
    pend_load     = 1'b0;
    case (state)
      ST_IDLE: begin
        if (Wr_En_X) begin
          act_load  = 1'b1;
          idx_nxt   = '0;
          state_nxt = ST_STREAM;
        end
      end
      ST_STREAM: begin
        if (last_beat) begin
          idx_nxt = '0;
          // Pending frame takes priority so frames leave in capture order.
          if (pend_v) begin
            act_load      = 1'b1;
            act_from_pend = 1'b1;
            if (Wr_En_X) pend_load  = 1'b1;
            else         pend_v_nxt = 1'b0;
          end else if (Wr_En_X) begin
            act_load = 1'b1;
          end else begin
            state_nxt = ST_IDLE;
          end
        end else begin
          if (xfer) idx_nxt = idx + IDX_W'(1);
          if (Wr_En_X) begin
            if (!pend_v) begin
              pend_load  = 1'b1;
              pend_v_nxt = 1'b1;
            end else begin
              drop_nxt = 1'b1;
            end
          end
        end
      end
      default: begin
        state_nxt  = ST_IDLE;
        idx_nxt    = '0;
        pend_v_nxt = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state    <= ST_IDLE;
      idx      <= '0;
      pend_v   <= 1'b0;
      drop_err <= 1'b0;
    end else begin
      state    <= state_nxt;
      idx      <= idx_nxt;
      pend_v   <= pend_v_nxt;
      drop_err <= drop_nxt;
    end
  end

  fft_frame_buf #(.N(N), .DATA_W(DATA_W), .IDX_W(IDX_W)) u_active (
    .clock    (clock),
    .load     (act_load),
    .load_re  (act_from_pend ? pend_vec_re : X_re_in),
    .load_im  (act_from_pend ? pend_vec_im : X_im_in),
    .load_ovf (act_from_pend ? pend_ovf    : Overflow),
    .rd_idx   (idx),
    .rd_re    (act_rd_re),
    .rd_im    (act_rd_im),
    .vec_re   (act_vec_re_unused),
    .vec_im   (act_vec_im_unused),
    .ovf      (act_ovf)
  );

  fft_frame_buf #(.N(N), .DATA_W(DATA_W), .IDX_W(IDX_W)) u_pending (
    .clock    (clock),
    .load     (pend_load),
    .load_re  (X_re_in),
    .load_im  (X_im_in),
    .load_ovf (Overflow),
    .rd_idx   (idx),
    .rd_re    (pend_rd_re_unused),
    .rd_im    (pend_rd_im_unused),
    .vec_re   (pend_vec_re),
    .vec_im   (pend_vec_im),
    .ovf      (pend_ovf)
  );

  // Gate data with the state so idle outputs read as zero regardless of buffer contents.
  assign out_valid = streaming;
  assign out_re    = streaming ? act_rd_re : '0;
  assign out_im    = streaming ? act_rd_im : '0;
  assign out_idx   = idx;
  assign out_last  = streaming & at_last;
  assign out_ovf   = streaming & act_ovf;
  assign busy      = pend_v;

endmodule

// File: tb/tb_fft_result_streamer.sv
// tb/tb_fft_result_streamer.sv - randomized and directed check of fft_result_streamer against a frame-level model
module tb_fft_result_streamer;

  localparam int N  = 8;
  localparam int DW = 16;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            wr;
  logic [N*DW-1:0] xre, xim;
  logic            ovf_in;
  logic            ready;
  logic            out_valid, out_last, out_ovf, busy, drop_err;
  logic [DW-1:0]   out_re, out_im;
  logic [2:0]      out_idx;

  int vec_cnt = 0;
  int err_cnt = 0;
  bit chk_en  = 0;

  // Frame-level model: the frame on the wire, its position, and a one-deep waiting frame.
  bit              m_stream, m_pend, m_drop, m_act_ovf, m_pend_ovf;
  int              m_pos;
  logic [N*DW-1:0] m_act_re, m_act_im, m_pend_re, m_pend_im;

  fft_result_streamer dut (
    .clock     (clk),
    .reset     (rst_n),
    .Wr_En_X   (wr),
    .X_re_in   (xre),
    .X_im_in   (xim),
    .Overflow  (ovf_in),
    .out_valid (out_valid),
    .out_ready (ready),
    .out_re    (out_re),
    .out_im    (out_im),
    .out_idx   (out_idx),
    .out_last  (out_last),
    .out_ovf   (out_ovf),
    .busy      (busy),
    .drop_err  (drop_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vec_cnt++;
    if (act !== exp) begin
      err_cnt++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  function automatic logic [N*DW-1:0] seq_re(input int base);
    logic [N*DW-1:0] v;
    for (int k = 0; k < N; k++) v[k*DW +: DW] = DW'(base + k + 1);
    return v;
  endfunction

  function automatic logic [N*DW-1:0] seq_im(input int base);
    logic [N*DW-1:0] v;
    for (int k = 0; k < N; k++) v[k*DW +: DW] = DW'(-(base + k + 1));
    return v;
  endfunction

  initial forever begin
    @(posedge clk);
    if (!rst_n) begin
      m_stream = 0; m_pos = 0; m_pend = 0; m_drop = 0;
    end else begin
      m_drop = 0;
      if (!m_stream) begin
        if (wr) begin
          m_act_re = xre; m_act_im = xim; m_act_ovf = ovf_in;
          m_stream = 1; m_pos = 0;
        end
      end else if (ready && m_pos == N-1) begin
        m_pos = 0;
        if (m_pend) begin
          m_act_re = m_pend_re; m_act_im = m_pend_im; m_act_ovf = m_pend_ovf;
          if (wr) begin
            m_pend_re = xre; m_pend_im = xim; m_pend_ovf = ovf_in;
          end else m_pend = 0;
        end else if (wr) begin
          m_act_re = xre; m_act_im = xim; m_act_ovf = ovf_in;
        end else m_stream = 0;
      end else begin
        if (ready) m_pos++;
        if (wr) begin
          if (!m_pend) begin
            m_pend_re = xre; m_pend_im = xim; m_pend_ovf = ovf_in; m_pend = 1;
          end else m_drop = 1;
        end
      end
    end
  end

  initial forever begin
    @(negedge clk);
    if (chk_en) begin
      chk("valid", {31'b0, out_valid}, {31'b0, m_stream});
      chk("re",    {16'b0, out_re},   m_stream ? {16'b0, m_act_re[m_pos*DW +: DW]} : 32'd0);
      chk("im",    {16'b0, out_im},   m_stream ? {16'b0, m_act_im[m_pos*DW +: DW]} : 32'd0);
      chk("idx",   {29'b0, out_idx},  32'(m_pos));
      chk("last",  {31'b0, out_last}, {31'b0, m_stream && m_pos == N-1});
      chk("ovf",   {31'b0, out_ovf},  {31'b0, m_stream && m_act_ovf});
      chk("busy",  {31'b0, busy},     {31'b0, m_pend});
      chk("drop",  {31'b0, drop_err}, {31'b0, m_drop});
    end
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic load_frame(input int base, input bit ovf);
    xre = seq_re(base); xim = seq_im(base); ovf_in = ovf; wr = 1;
  endtask

  initial begin
    int nx, s2, s5;
    rst_n = 0; wr = 0; ready = 1; ovf_in = 0; xre = '0; xim = '0;
    tick(); chk_en = 1;
    tick();
    rst_n = 1;
    repeat (3) tick();
    chk("rst_valid", {31'b0, out_valid}, 32'd0);
    chk("rst_busy",  {31'b0, busy},      32'd0);

    // Single frame, re[k]=k+1, im[k]=-(k+1)
    load_frame(0, 0); tick(); wr = 0;
    chk("sf_first_valid", {31'b0, out_valid}, 32'd1);
    chk("sf_first_re",    {16'b0, out_re},    32'h0001);
    chk("sf_first_im",    {16'b0, out_im},    32'hFFFF);
    repeat (7) tick();
    chk("sf_last_re",   {16'b0, out_re},   32'h0008);
    chk("sf_last_im",   {16'b0, out_im},   32'hFFF8);
    chk("sf_last_flag", {31'b0, out_last}, 32'd1);
    tick();
    chk("sf_idle", {31'b0, out_valid}, 32'd0);

    // Back-pressure: stall 3 cycles at bins 2 and 5
    load_frame(0, 0); tick(); wr = 0;
    nx = 0; s2 = 0; s5 = 0;
    for (int c = 0; c < 20; c++) begin
      ready = 1;
      if (out_valid && out_idx == 3'd2 && s2 < 3) begin ready = 0; s2++; end
      if (out_valid && out_idx == 3'd5 && s5 < 3) begin ready = 0; s5++; end
      if (out_valid && ready) begin
        chk("bp_order", {29'b0, out_idx}, 32'(nx));
        nx++;
      end
      tick();
    end
    ready = 1;
    chk("bp_count", 32'(nx), 32'd8);

    // Pending slot and overrun: A (ovf=1), B at beat 3, C dropped at beat 5
    load_frame('h100, 1); tick(); wr = 0;
    chk("a_ovf", {31'b0, out_ovf}, 32'd1);
    repeat (3) tick();
    load_frame('h200, 0); tick(); wr = 0;
    chk("pend_busy", {31'b0, busy}, 32'd1);
    tick();
    load_frame('h700, 1); tick(); wr = 0;
    chk("drop_pulse", {31'b0, drop_err}, 32'd1);
    tick();
    chk("drop_clear", {31'b0, drop_err}, 32'd0);
    tick();
    chk("b_valid", {31'b0, out_valid}, 32'd1);
    chk("b_idx",   {29'b0, out_idx},   32'd0);
    chk("b_re",    {16'b0, out_re},    32'h0201);
    chk("b_ovf",   {31'b0, out_ovf},   32'd0);
    chk("b_busy",  {31'b0, busy},      32'd0);
    repeat (9) tick();

    // Capture coincident with last beat, no pending
    load_frame('h300, 0); tick(); wr = 0;
    repeat (7) tick();
    load_frame('h400, 0); tick(); wr = 0;
    chk("bnd_valid", {31'b0, out_valid}, 32'd1);
    chk("bnd_idx",   {29'b0, out_idx},   32'd0);
    chk("bnd_re",    {16'b0, out_re},    32'h0401);
    repeat (9) tick();

    // Reset mid-frame with pending occupied
    load_frame('h500, 0); tick(); wr = 0;
    tick();
    load_frame('h600, 0); tick(); wr = 0;
    repeat (2) tick();
    rst_n = 0; tick();
    chk("rst_mid_valid", {31'b0, out_valid}, 32'd0);
    chk("rst_mid_busy",  {31'b0, busy},      32'd0);
    rst_n = 1; tick();

    // Randomized traffic
    for (int c = 0; c < 3000; c++) begin
      wr     = ($urandom_range(7) == 0);
      ready  = ($urandom_range(3) != 0);
      ovf_in = 1'($urandom_range(1));
      rst_n  = ($urandom_range(499) != 0);
      xre    = {$urandom, $urandom, $urandom, $urandom};
      xim    = {$urandom, $urandom, $urandom, $urandom};
      tick();
    end
    wr = 0; rst_n = 1; ready = 1;
    repeat (20) tick();

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
